// File: rtl/thunderbird_seq_pkg.sv
// Shared types and helpers for the thunderbird_seq tail-light sequencer.
// The lamp count is a module parameter, so thermo() returns a wide code that callers truncate.
package thunderbird_pkg;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ_ON} tb_state_t;

  localparam int unsigned MAX_LAMPS = 32;

  // Thermometer code with the k least significant bits set.
  function automatic logic [MAX_LAMPS-1:0] thermo(input int unsigned k);
    logic [MAX_LAMPS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
      if (i < k) begin
        t[i] = 1'b1;
      end else begin
        t[i] = 1'b0;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/thunderbird_seq_tick_gen.sv
// Free-running prescaler for thunderbird_seq.
// tick marks the last cycle of every PRESCALE-cycle step.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: wrap to zero on the last cycle of the step.
  always_comb begin
    count_d = count_q;
    tick = (count_q == CNT_LAST);
    if (tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/thunderbird_seq.sv
// Thunderbird tail-light sequencer: LAMPS lamps per side, one step per PRESCALE clocks,
// with a hazard mode that overrides and aborts a turn sequence.
module thunderbird_seq
  import thunderbird_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  output logic [LAMPS-1:0] l_lamps,
  output logic [LAMPS-1:0] r_lamps,
  output logic             busy
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);

  logic tick;

  tb_state_t        state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [LAMPS-1:0] l_lamps_q, l_lamps_d;
  logic [LAMPS-1:0] r_lamps_q, r_lamps_d;
  logic             busy_q, busy_d;
  logic [LAMPS-1:0] therm_s;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Next-state logic; state and step only advance on tick.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (hazard || (left && right)) begin
            state_d = HAZ_ON;
            step_d  = '0;
          end else if (left) begin
            state_d = LEFT;
            step_d  = STEP_ONE;
          end else if (right) begin
            state_d = RIGHT;
            step_d  = STEP_ONE;
          end else begin
            state_d = IDLE;
            step_d  = '0;
          end
        end
        LEFT, RIGHT: begin
          if (hazard) begin
            state_d = HAZ_ON;
            step_d  = '0;
          end else if (step_q < STEP_LAST) begin
            step_d = step_q + STEP_ONE;
          end else begin
            state_d = IDLE;
            step_d  = '0;
          end
        end
        HAZ_ON: begin
          state_d = IDLE;
          step_d  = '0;
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      step_d  = step_q;
    end
  end

  // Lamp decode from the next state so the outputs can be registered without extra latency.
  always_comb begin
    l_lamps_d = '0;
    r_lamps_d = '0;
    therm_s   = LAMPS'(thermo(32'(step_d)));
    busy_d    = (state_d != IDLE);
    case (state_d)
      LEFT:    l_lamps_d = therm_s;
      RIGHT:   r_lamps_d = therm_s;
      HAZ_ON: begin
        l_lamps_d = '1;
        r_lamps_d = '1;
      end
      default: begin
        l_lamps_d = '0;
        r_lamps_d = '0;
      end
    endcase
  end

  // State, step and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      l_lamps_q <= '0;
      r_lamps_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      l_lamps_q <= l_lamps_d;
      r_lamps_q <= r_lamps_d;
      busy_q    <= busy_d;
    end
  end

  assign l_lamps = l_lamps_q;
  assign r_lamps = r_lamps_q;
  assign busy    = busy_q;

endmodule
